branch_ctrl: RTL

//  - ID-stage branch sequencer for the pipelined MIPS core. Drives the cmp block:
//    cmp_sel pass-through, operand forward selects, and branch-decision timing.
//  - Detects RAW hazards on the comparator operands and stalls the front end for
//    1 or 2 cycles until operands are forwardable.
//  - Issues taken/flush to PC and IF/ID. Keeps branch performance counters.

---
 rtl/branch_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/branch_ctrl.sv
// ID-stage branch sequencer: drives the comparator's operation select and
// operand forward selects, stalls on comparator RAW hazards, issues
// taken/flush, and keeps branch performance counters.
module branch_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_branch,
    input  logic [2:0]       id_cmp_sel,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             mem_regwrite,
    input  logic             mem_memread,
    input  logic [4:0]       mem_rd,
    input  logic             wb_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic             cmp_zero,
    input  logic             flush_in,
    output logic [2:0]       cmp_sel,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic             br_taken,
    output logic             flush_ifid,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [CNT_W-1:0] cnt_stall
);

    localparam int unsigned WCNT_W = 2;
    localparam int unsigned FWD_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic [WCNT_W-1:0] need;
    logic [FWD_W-1:0]  fwd_a_raw, fwd_b_raw;
    logic              resolve;
    logic              use_b;
    logic              ex_hit, mem_hit;

    // r0 never matches a producer
    function automatic logic dep(input logic [4:0] src, input logic we, input logic [4:0] rd);
        return we && (src != 5'd0) && (src == rd);
    endfunction

    assign cmp_sel = id_cmp_sel;
    assign use_b   = (id_cmp_sel == 3'd4) || (id_cmp_sel == 3'd5);

    // Hazard classification: how many stall cycles the branch in ID needs
    always_comb begin
        ex_hit  = dep(id_rs, ex_regwrite, ex_rd) || (use_b && dep(id_rt, ex_regwrite, ex_rd));
        mem_hit = dep(id_rs, mem_regwrite, mem_rd) || (use_b && dep(id_rt, mem_regwrite, mem_rd));
        need    = '0;
        if (ex_hit && ex_memread)        need = WCNT_W'(2);
        else if (ex_hit)                 need = WCNT_W'(1);
        else if (mem_hit && mem_memread) need = WCNT_W'(1);
    end

    // Operand forward selects; a load in MEM is never forwarded (stall covers it)
    always_comb begin
        fwd_a_raw = '0;
        fwd_b_raw = '0;
        if (dep(id_rs, mem_regwrite, mem_rd) && !mem_memread) fwd_a_raw = FWD_W'(1);
        else if (dep(id_rs, wb_regwrite, wb_rd))             fwd_a_raw = FWD_W'(2);
        if (use_b) begin
            if (dep(id_rt, mem_regwrite, mem_rd) && !mem_memread) fwd_b_raw = FWD_W'(1);
            else if (dep(id_rt, wb_regwrite, wb_rd))             fwd_b_raw = FWD_W'(2);
        end
        fwd_a = rst_n ? fwd_a_raw : '0;
        fwd_b = rst_n ? fwd_b_raw : '0;
    end

    // Next-state and control outputs; wcnt holds extra STALL cycles beyond the first
    always_comb begin
        state_nxt  = state;
        wcnt_nxt   = wcnt;
        stall      = 1'b0;
        resolve    = 1'b0;
        br_taken   = 1'b0;
        flush_ifid = 1'b0;
        unique case (state)
            IDLE: begin
                if (id_branch) begin
                    if (need == '0) begin
                        resolve = 1'b1;
                    end else begin
                        stall = 1'b1;
                        if (need == WCNT_W'(2)) begin
                            state_nxt = STALL;
                            wcnt_nxt  = '0;
                        end
                    end
                end
            end
            STALL: begin
                stall = 1'b1;
                if (wcnt == '0) state_nxt = IDLE;
                else            wcnt_nxt  = wcnt - WCNT_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
        if (flush_in) begin
            state_nxt = IDLE;
            wcnt_nxt  = '0;
            stall     = 1'b0;
            resolve   = 1'b0;
        end
        if (!rst_n) begin
            stall   = 1'b0;
            resolve = 1'b0;
        end
        br_taken   = resolve && cmp_zero;
        flush_ifid = resolve && cmp_zero;
    end

    // State and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Performance counters, wrapping silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_branch <= '0;
            cnt_taken  <= '0;
            cnt_stall  <= '0;
        end else begin
            cnt_branch <= cnt_branch + CNT_W'(resolve);
            cnt_taken  <= cnt_taken + CNT_W'(br_taken);
            cnt_stall  <= cnt_stall + CNT_W'(stall);
        end
    end

endmodule
